// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath select and enable.
module multicycle_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic [3:0] state,
    output logic       instrDone,
    output logic       invalidOp
);

    localparam int unsigned STATE_W = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] FN_JR   = 6'b001000;

    typedef enum logic [STATE_W-1:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        JR        = 4'd10,
        ADDI_EX   = 4'd11,
        ADDI_WB   = 4'd12
    } state_t;

    state_t cur;
    state_t nxt;

    // State register; reset overrides any in-flight instruction or stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur <= FETCH;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state logic; opcode/funct only matter in DECODE and MEM_ADDR.
    always_comb begin
        nxt = FETCH;
        unique case (cur)
            FETCH:     nxt = memReady ? DECODE : FETCH;
            DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: nxt = MEM_ADDR;
                    OP_R:         nxt = (funct == FN_JR) ? JR : EXECUTE;
                    OP_BEQ:       nxt = BRANCH;
                    OP_J:         nxt = JUMP;
                    OP_ADDI:      nxt = ADDI_EX;
                    default:      nxt = FETCH;
                endcase
            end
            MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    nxt = MEM_READ;
                end else if (opcode == OP_SW) begin
                    nxt = MEM_WRITE;
                end else begin
                    nxt = FETCH;
                end
            end
            MEM_READ:  nxt = memReady ? MEM_WB : MEM_READ;
            MEM_WB:    nxt = FETCH;
            MEM_WRITE: nxt = memReady ? FETCH : MEM_WRITE;
            EXECUTE:   nxt = R_WB;
            R_WB:      nxt = FETCH;
            BRANCH:    nxt = FETCH;
            JUMP:      nxt = FETCH;
            JR:        nxt = FETCH;
            ADDI_EX:   nxt = ADDI_WB;
            ADDI_WB:   nxt = FETCH;
            default:   nxt = FETCH;
        endcase
    end

    // Moore output decode from the state register; memReady only gates the
    // fetch-time IR/PC loads and the store completion flag.
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSource    = 2'b00;
        instrDone   = 1'b0;
        invalidOp   = 1'b0;
        unique case (cur)
            FETCH: begin
                memRead = 1'b1;
                irWrite = memReady;
                pcWrite = memReady;
                aluSrcB = 2'b01;
            end
            DECODE: begin
                aluSrcB = 2'b11;
                unique case (opcode)
                    OP_LW, OP_SW, OP_R, OP_BEQ, OP_J, OP_ADDI: invalidOp = 1'b0;
                    default:                                   invalidOp = 1'b1;
                endcase
            end
            MEM_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            MEM_READ: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            MEM_WB: begin
                regWrite  = 1'b1;
                memToReg  = 1'b1;
                instrDone = 1'b1;
            end
            MEM_WRITE: begin
                memWrite  = 1'b1;
                iorD      = 1'b1;
                instrDone = memReady;
            end
            EXECUTE: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
            end
            R_WB: begin
                regWrite  = 1'b1;
                regDst    = 1'b1;
                instrDone = 1'b1;
            end
            BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
                instrDone   = 1'b1;
            end
            JUMP: begin
                pcWrite   = 1'b1;
                pcSource  = 2'b10;
                instrDone = 1'b1;
            end
            JR: begin
                pcWrite   = 1'b1;
                pcSource  = 2'b11;
                instrDone = 1'b1;
            end
            ADDI_EX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            ADDI_WB: begin
                regWrite  = 1'b1;
                instrDone = 1'b1;
            end
            default: begin
                pcWrite = 1'b0;
            end
        endcase
    end

    assign state = STATE_W'(cur);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each step queues the expected output
// vector for the cycle and compares it against the DUT mid-cycle.
module tb_multicycle_control;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       memReady;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] state;
    logic       instrDone, invalidOp;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_JR   = 6'b001000;

    int n_cmp = 0;
    int n_bad = 0;

    logic [21:0] sb_q[$];
    string       tag_q[$];

    multicycle_control dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .memReady(memReady), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
        .iorD(iorD), .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .state(state), .instrDone(instrDone),
        .invalidOp(invalidOp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs for a state, written from the state/output table.
    function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic mr, input logic inv);
        logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, idone, iop;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, idone, iop} = 12'b0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            4'd0:  begin mrd = 1'b1; irw = mr; pw = mr; asb = 2'b01; end
            4'd1:  begin asb = 2'b11; iop = inv; end
            4'd2:  begin asa = 1'b1; asb = 2'b10; end
            4'd3:  begin mrd = 1'b1; iod = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; idone = 1'b1; end
            4'd5:  begin mwr = 1'b1; iod = 1'b1; idone = mr; end
            4'd6:  begin asa = 1'b1; aop = 2'b10; end
            4'd7:  begin rw = 1'b1; rdst = 1'b1; idone = 1'b1; end
            4'd8:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; idone = 1'b1; end
            4'd9:  begin pw = 1'b1; psrc = 2'b10; idone = 1'b1; end
            4'd10: begin pw = 1'b1; psrc = 2'b11; idone = 1'b1; end
            4'd11: begin asa = 1'b1; asb = 2'b10; end
            4'd12: begin rw = 1'b1; idone = 1'b1; end
            default: ;
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, st, idone, iop};
    endfunction

    // One clock cycle: drive inputs, queue the expectation, compare, advance.
    task automatic step(input logic rst, input logic mr, input logic [5:0] opc,
                        input logic [5:0] fn, input logic [3:0] st, input logic inv,
                        input string tag);
        logic [21:0] obs;
        logic [21:0] ex;
        string       t;
        @(negedge clock);
        reset    = rst;
        memReady = mr;
        opcode   = opc;
        funct    = fn;
        sb_q.push_back(exp_vec(st, mr, inv));
        tag_q.push_back(tag);
        #1;
        obs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
               regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, state,
               instrDone, invalidOp};
        ex = sb_q.pop_front();
        t  = tag_q.pop_front();
        n_cmp++;
        assert (obs === ex) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (state %0d)", t, obs, ex, state);
        end
    endtask

    initial begin
        reset = 1'b1; memReady = 1'b1; opcode = OP_LW; funct = 6'd0;
        @(posedge clock);
        @(posedge clock);

        step(1'b1, 1'b1, OP_LW, 6'd0, 4'd0, 1'b0, "reset_state");

        // lw, no stalls
        step(1'b0, 1'b1, OP_LW, 6'd0, 4'd0, 1'b0, "lw_fetch");
        step(1'b0, 1'b1, OP_LW, 6'd0, 4'd1, 1'b0, "lw_decode");
        step(1'b0, 1'b1, OP_LW, 6'd0, 4'd2, 1'b0, "lw_addr");
        step(1'b0, 1'b1, OP_LW, 6'd0, 4'd3, 1'b0, "lw_read");
        step(1'b0, 1'b1, OP_LW, 6'd0, 4'd4, 1'b0, "lw_wb");

        // R-type add; opcode garbage after decode must be ignored
        step(1'b0, 1'b1, OP_R, FN_ADD, 4'd0, 1'b0, "r_fetch");
        step(1'b0, 1'b1, OP_R, FN_ADD, 4'd1, 1'b0, "r_decode");
        step(1'b0, 1'b1, OP_BAD, 6'd0, 4'd6, 1'b0, "r_exec");
        step(1'b0, 1'b1, OP_BAD, 6'd0, 4'd7, 1'b0, "r_wb");

        // jr
        step(1'b0, 1'b1, OP_R, FN_JR, 4'd0, 1'b0, "jr_fetch");
        step(1'b0, 1'b1, OP_R, FN_JR, 4'd1, 1'b0, "jr_decode");
        step(1'b0, 1'b1, OP_R, FN_JR, 4'd10, 1'b0, "jr_exec");

        // sw with two stall cycles in MEM_WRITE
        step(1'b0, 1'b1, OP_SW, 6'd0, 4'd0, 1'b0, "sw_fetch");
        step(1'b0, 1'b1, OP_SW, 6'd0, 4'd1, 1'b0, "sw_decode");
        step(1'b0, 1'b1, OP_SW, 6'd0, 4'd2, 1'b0, "sw_addr");
        step(1'b0, 1'b0, OP_SW, 6'd0, 4'd5, 1'b0, "sw_stall1");
        step(1'b0, 1'b0, OP_SW, 6'd0, 4'd5, 1'b0, "sw_stall2");
        step(1'b0, 1'b1, OP_SW, 6'd0, 4'd5, 1'b0, "sw_done");

        // fetch stall for four cycles, then beq
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, OP_BEQ, 6'd0, 4'd0, 1'b0, "fetch_stall");
        end
        step(1'b0, 1'b1, OP_BEQ, 6'd0, 4'd0, 1'b0, "beq_fetch");
        step(1'b0, 1'b1, OP_BEQ, 6'd0, 4'd1, 1'b0, "beq_decode");
        step(1'b0, 1'b1, OP_BEQ, 6'd0, 4'd8, 1'b0, "beq_branch");

        // unsupported opcode
        step(1'b0, 1'b1, OP_BAD, 6'd0, 4'd0, 1'b0, "bad_fetch");
        step(1'b0, 1'b1, OP_BAD, 6'd0, 4'd1, 1'b1, "bad_decode");
        step(1'b0, 1'b1, OP_BAD, 6'd0, 4'd0, 1'b0, "bad_back");

        // reset held three cycles while stalled in MEM_READ
        step(1'b0, 1'b1, OP_LW, 6'd0, 4'd1, 1'b0, "lw2_decode");
        step(1'b0, 1'b1, OP_LW, 6'd0, 4'd2, 1'b0, "lw2_addr");
        step(1'b0, 1'b0, OP_LW, 6'd0, 4'd3, 1'b0, "lw2_read_stall");
        step(1'b1, 1'b0, OP_LW, 6'd0, 4'd3, 1'b0, "rst_mid_lw1");
        step(1'b1, 1'b0, OP_LW, 6'd0, 4'd0, 1'b0, "rst_mid_lw2");
        step(1'b1, 1'b0, OP_LW, 6'd0, 4'd0, 1'b0, "rst_mid_lw3");
        step(1'b0, 1'b1, OP_J, 6'd0, 4'd0, 1'b0, "post_rst_fetch");

        // j
        step(1'b0, 1'b1, OP_J, 6'd0, 4'd1, 1'b0, "j_decode");
        step(1'b0, 1'b1, OP_J, 6'd0, 4'd9, 1'b0, "j_jump");

        // addi
        step(1'b0, 1'b1, OP_ADDI, 6'd0, 4'd0, 1'b0, "addi_fetch");
        step(1'b0, 1'b1, OP_ADDI, 6'd0, 4'd1, 1'b0, "addi_decode");
        step(1'b0, 1'b1, OP_ADDI, 6'd0, 4'd11, 1'b0, "addi_ex");
        step(1'b0, 1'b1, OP_ADDI, 6'd0, 4'd12, 1'b0, "addi_wb");
        step(1'b0, 1'b1, OP_ADDI, 6'd0, 4'd0, 1'b0, "addi_next_fetch");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
